mem_port_arbiter: RTL and testbench

//   Shares one unified memory port between instruction fetch (IF, read-only) and the
//   MEM-stage load/store unit of the 5-stage core. One outstanding transaction at a time.

---
 rtl/mem_port_arbiter_pkg.sv | 17 +
 rtl/mem_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified memory port arbiter: FSM states and the
// owner of the transaction currently on the bus.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between instruction fetch and the load/store
// unit. One transaction in flight at a time; data wins ties because it
// belongs to the older instruction. Flushed fetches still finish on the bus
// but never raise if_valid.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_flush,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_valid,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_valid,
  output logic                m_req,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_be,
  input  logic                m_ready,
  input  logic                m_rvalid,
  input  logic [DATA_W-1:0]   m_rdata,
  output logic                stall_if,
  output logic                stall_mem
);
  import mem_port_arbiter_pkg::*;

  localparam int BE_W = DATA_W / 8;

  state_t              state_reg, state_next;
  owner_t              owner_reg, owner_next;
  logic                drop_reg, drop_next;
  logic                m_req_reg, m_req_next;
  logic                m_we_reg, m_we_next;
  logic [ADDR_W-1:0]   m_addr_reg, m_addr_next;
  logic [DATA_W-1:0]   m_wdata_reg, m_wdata_next;
  logic [BE_W-1:0]     m_be_reg, m_be_next;
  logic [DATA_W-1:0]   if_rdata_reg, if_rdata_next;
  logic [DATA_W-1:0]   d_rdata_reg, d_rdata_next;
  logic                in_resp;

  // State, request payload and captured read data registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      owner_reg    <= OWN_FETCH;
      drop_reg     <= 1'b0;
      m_req_reg    <= 1'b0;
      m_we_reg     <= 1'b0;
      m_addr_reg   <= '0;
      m_wdata_reg  <= '0;
      m_be_reg     <= '0;
      if_rdata_reg <= '0;
      d_rdata_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      owner_reg    <= owner_next;
      drop_reg     <= drop_next;
      m_req_reg    <= m_req_next;
      m_we_reg     <= m_we_next;
      m_addr_reg   <= m_addr_next;
      m_wdata_reg  <= m_wdata_next;
      m_be_reg     <= m_be_next;
      if_rdata_reg <= if_rdata_next;
      d_rdata_reg  <= d_rdata_next;
    end
  end

  // Next-state logic: pick a requester, hold the request until accepted,
  // wait for the response, then spend exactly one cycle reporting it.
  always_comb begin
    state_next    = state_reg;
    owner_next    = owner_reg;
    drop_next     = drop_reg;
    m_req_next    = m_req_reg;
    m_we_next     = m_we_reg;
    m_addr_next   = m_addr_reg;
    m_wdata_next  = m_wdata_reg;
    m_be_next     = m_be_reg;
    if_rdata_next = if_rdata_reg;
    d_rdata_next  = d_rdata_reg;
    case (state_reg)
      ST_IDLE: begin
        if (d_req) begin
          m_we_next    = d_we;
          m_addr_next  = d_addr;
          m_wdata_next = d_wdata;
          m_be_next    = d_be;
          owner_next   = OWN_DATA;
          m_req_next   = 1'b1;
          state_next   = ST_ISSUE;
        end else if (if_req && !if_flush) begin
          m_we_next    = 1'b0;
          m_addr_next  = if_addr;
          m_be_next    = '1;
          owner_next   = OWN_FETCH;
          m_req_next   = 1'b1;
          state_next   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (if_flush && owner_reg == OWN_FETCH) drop_next = 1'b1;
        if (m_ready) begin
          m_req_next = 1'b0;
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (if_flush && owner_reg == OWN_FETCH) drop_next = 1'b1;
        if (m_rvalid) begin
          if (owner_reg == OWN_DATA) d_rdata_next = m_rdata;
          else                       if_rdata_next = m_rdata;
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        drop_next  = 1'b0;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Completion pulses come straight from the RESP state so a flush in that
  // same cycle can still suppress the fetch result.
  assign in_resp  = (state_reg == ST_RESP);
  assign d_valid  = in_resp && (owner_reg == OWN_DATA);
  assign if_valid = in_resp && (owner_reg == OWN_FETCH) && !drop_reg && !if_flush;

  assign stall_if  = if_req & ~if_valid;
  assign stall_mem = d_req & ~d_valid;

  assign m_req    = m_req_reg;
  assign m_we     = m_we_reg;
  assign m_addr   = m_addr_reg;
  assign m_wdata  = m_wdata_reg;
  assign m_be     = m_be_reg;
  assign if_rdata = if_rdata_reg;
  assign d_rdata  = d_rdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a memory responder, a transaction
// scoreboard checked every cycle, and literal checks for each scenario.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_flush, if_valid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_valid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be;
  logic        m_req, m_we, m_ready, m_rvalid;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_be;
  logic        stall_if, stall_mem;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  int checks_total  = 0;
  int checks_passed = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endfunction

  // Memory contents as seen by the bus; unwritten words read a fixed pattern.
  logic [31:0] mem [logic [31:0]];
  function automatic logic [31:0] mem_rd(logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A0000;
  endfunction

  typedef struct packed {logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be;} bus_t;
  typedef struct packed {logic is_load; logic [31:0] data;} dresp_t;
  bus_t   exp_bus[$];
  logic [31:0] exp_if[$];
  dresp_t exp_d[$];

  // Responder configuration and state.
  int          ready_low    = 0;
  int          rvalid_delay = 1;
  int          resp_cnt     = 0;
  logic [31:0] resp_addr;
  logic [31:0] rsp_word;

  // Memory responder: accept on m_req&m_ready, answer rvalid_delay cycles later.
  initial begin
    m_ready = 1'b1; m_rvalid = 1'b0; m_rdata = '0; resp_addr = '0; rsp_word = '0;
    forever begin
      @(negedge clk);
      if (m_req && m_ready && !reset) begin
        resp_addr = m_addr;
        if (m_we) begin
          rsp_word = mem_rd(m_addr);
          for (int b = 0; b < 4; b++)
            if (m_be[b]) rsp_word[8*b +: 8] = m_wdata[8*b +: 8];
          mem[m_addr] = rsp_word;
        end
        resp_cnt = rvalid_delay;
      end
      @(posedge clk); #1;
      m_rvalid = 1'b0;
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          m_rvalid = 1'b1;
          m_rdata  = mem_rd(resp_addr);
        end
      end
      if (m_req && ready_low > 0) begin
        m_ready = 1'b0;
        ready_low--;
      end else begin
        m_ready = 1'b1;
      end
    end
  end

  // Per-cycle scoreboard: stall rules, bus payload vs expected order,
  // completion pulses vs expected results.
  int     mreq_cycles = 0;
  bus_t   e_bus;
  dresp_t e_d;
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("stall_if", {31'b0, stall_if}, {31'b0, if_req && !if_valid});
        chk("stall_mem", {31'b0, stall_mem}, {31'b0, d_req && !d_valid});
        if (m_req) begin
          mreq_cycles++;
          chk("m_req_expected", exp_bus.size() > 0, 1);
          if (exp_bus.size() > 0) begin
            e_bus = exp_bus[0];
            chk("m_we", {31'b0, m_we}, {31'b0, e_bus.we});
            chk("m_addr", m_addr, e_bus.addr);
            chk("m_be", {28'b0, m_be}, {28'b0, e_bus.be});
            if (e_bus.we) chk("m_wdata", m_wdata, e_bus.wdata);
            if (m_ready) void'(exp_bus.pop_front());
          end
        end
        if (if_valid) begin
          chk("if_valid_expected", exp_if.size() > 0, 1);
          if (exp_if.size() > 0) chk("if_rdata", if_rdata, exp_if.pop_front());
        end
        if (d_valid) begin
          chk("d_valid_expected", exp_d.size() > 0, 1);
          if (exp_d.size() > 0) begin
            e_d = exp_d.pop_front();
            if (e_d.is_load) chk("d_rdata", d_rdata, e_d.data);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Hold a fetch until if_valid; report clock edges from request to pulse.
  task automatic do_fetch(input logic [31:0] addr, output int edges);
    int  n = 0;
    bit  seen = 0;
    if_req = 1'b1; if_addr = addr;
    while (!seen && n < 60) begin
      @(negedge clk); n++; seen = if_valid;
    end
    if (!seen) chk("fetch_timeout", {31'b0, if_valid}, 1);
    edges = n - 1;
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  task automatic do_data(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, output int edges);
    int  n = 0;
    bit  seen = 0;
    d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_be = be;
    while (!seen && n < 60) begin
      @(negedge clk); n++; seen = d_valid;
    end
    if (!seen) chk("data_timeout", {31'b0, d_valid}, 1);
    edges = n - 1;
    @(posedge clk); #1;
    d_req = 1'b0;
  endtask

  task automatic wait_accept();
    int n = 0;
    bit seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk); n++; seen = m_req && m_ready;
    end
    if (!seen) chk("accept_timeout", {31'b0, m_req && m_ready}, 1);
  endtask

  int lat_f, lat_d;

  initial begin
    reset = 1'b1;
    if_req = 0; if_addr = '0; if_flush = 0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_be = '0;
    mem[32'h100]  = 32'h00500093;
    mem[32'h2000] = 32'h00C0FFEE;
    mem[32'h2004] = 32'h11223344;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_m_req", {31'b0, m_req}, 0);
    chk("rst_m_we", {31'b0, m_we}, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_if_valid", {31'b0, if_valid}, 0);
    chk("rst_d_valid", {31'b0, d_valid}, 0);
    chk("rst_if_rdata", if_rdata, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    tick();

    // 1: single fetch, 3-edge latency
    $display("T1 fetch 0x100");
    exp_bus.push_back('{we: 1'b0, addr: 32'h100, wdata: 32'h0, be: 4'hF});
    exp_if.push_back(32'h00500093);
    do_fetch(32'h100, lat_f);
    chk("t1_latency", lat_f, 3);
    chk("t1_if_rdata_hold", if_rdata, 32'h00500093);

    // 2: simultaneous fetch and load; data goes first
    $display("T2 fetch 0x104 + load 0x2000 together");
    exp_bus.push_back('{we: 1'b0, addr: 32'h2000, wdata: 32'h0, be: 4'hF});
    exp_bus.push_back('{we: 1'b0, addr: 32'h104, wdata: 32'h0, be: 4'hF});
    exp_d.push_back('{is_load: 1'b1, data: 32'h00C0FFEE});
    exp_if.push_back(mem_rd(32'h104));
    fork
      do_data(1'b0, 32'h2000, 32'h0, 4'hF, lat_d);
      do_fetch(32'h104, lat_f);
    join
    chk("t2_load_latency", lat_d, 3);
    chk("t2_fetch_waits", {31'b0, lat_f > lat_d}, 1);

    // 3: partial store, then read back the merged word
    $display("T3 store 0x2004 be=0011");
    exp_bus.push_back('{we: 1'b1, addr: 32'h2004, wdata: 32'hDEADBEEF, be: 4'b0011});
    exp_d.push_back('{is_load: 1'b0, data: 32'h0});
    do_data(1'b1, 32'h2004, 32'hDEADBEEF, 4'b0011, lat_d);
    chk("t3_store_latency", lat_d, 3);
    exp_bus.push_back('{we: 1'b0, addr: 32'h2004, wdata: 32'h0, be: 4'hF});
    exp_d.push_back('{is_load: 1'b1, data: 32'h1122BEEF});
    do_data(1'b0, 32'h2004, 32'h0, 4'hF, lat_d);

    // 4: flush during WAIT drops the fetch result
    $display("T4 fetch 0x200 flushed in WAIT");
    rvalid_delay = 3;
    exp_bus.push_back('{we: 1'b0, addr: 32'h200, wdata: 32'h0, be: 4'hF});
    if_req = 1'b1; if_addr = 32'h200;
    wait_accept();
    @(posedge clk); #1;
    if_flush = 1'b1; if_req = 1'b0;
    tick();
    if_flush = 1'b0;
    repeat (6) tick();
    chk("t4_dropped_if_rdata", if_rdata, 32'h5A5A0200);
    rvalid_delay = 1;
    exp_bus.push_back('{we: 1'b0, addr: 32'h104, wdata: 32'h0, be: 4'hF});
    exp_if.push_back(mem_rd(32'h104));
    do_fetch(32'h104, lat_f);
    chk("t4_next_fetch_latency", lat_f, 3);

    // 5: m_ready low for 5 cycles
    $display("T5 fetch 0x108 with m_ready low 5 cycles");
    ready_low = 5;
    mreq_cycles = 0;
    exp_bus.push_back('{we: 1'b0, addr: 32'h108, wdata: 32'h0, be: 4'hF});
    exp_if.push_back(mem_rd(32'h108));
    do_fetch(32'h108, lat_f);
    chk("t5_m_req_cycles", mreq_cycles, 6);
    chk("t5_latency", lat_f, 8);

    // 6: reset while waiting for the response, response arrives late
    $display("T6 load 0x3000 reset in WAIT");
    rvalid_delay = 4;
    exp_bus.push_back('{we: 1'b0, addr: 32'h3000, wdata: 32'h0, be: 4'hF});
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000; d_be = 4'hF;
    wait_accept();
    @(posedge clk); #1;
    tick();
    reset = 1'b1; d_req = 1'b0;
    @(negedge clk);
    chk("t6_m_req", {31'b0, m_req}, 0);
    chk("t6_m_addr", m_addr, 0);
    chk("t6_m_be", {28'b0, m_be}, 0);
    chk("t6_d_rdata", d_rdata, 0);
    chk("t6_if_rdata", if_rdata, 0);
    chk("t6_d_valid", {31'b0, d_valid}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (6) tick();
    chk("t6_d_rdata_after_late_rvalid", d_rdata, 0);
    chk("t6_m_req_idle", {31'b0, m_req}, 0);
    rvalid_delay = 1;

    // Every expected transaction and completion was consumed
    chk("bus_drained", exp_bus.size(), 0);
    chk("if_drained", exp_if.size(), 0);
    chk("d_drained", exp_d.size(), 0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
